// File: rtl/traffic_main_if.sv
// traffic_main_if: sensor inputs and lamp/flag outputs of the intersection controller
interface traffic_main_if;
  logic C, Emergency, MR, MY, MG, SR, SY, SG, ST;
  modport master(output C, Emergency, input MR, MY, MG, SR, SY, SG, ST);
  modport slave(input C, Emergency, output MR, MY, MG, SR, SY, SG, ST);
endinterface

// File: rtl/traffic_main.sv
// traffic_main: main/side-road Moore traffic-light FSM with dwell timer and emergency override
module traffic_main #(
  parameter int LONG_CYCLES  = 5,
  parameter int SHORT_CYCLES = 2,
  parameter int TIMER_W      = 8
) (
  input  logic         Clk,
  input  logic         reset,
  traffic_main_if.slave bus
);
  localparam logic [1:0] MAIN_G = 2'd0;
  localparam logic [1:0] MAIN_Y = 2'd1;
  localparam logic [1:0] SIDE_G = 2'd2;
  localparam logic [1:0] SIDE_Y = 2'd3;
  logic [1:0] state, state_nx;
  logic [TIMER_W-1:0] cnt;
  logic tl, ts, go;
  // encoding is the visiting order, so a transition is always state+1
  always_comb begin
    tl = cnt >= TIMER_W'(LONG_CYCLES - 1);
    ts = cnt >= TIMER_W'(SHORT_CYCLES - 1);
    go = state == MAIN_G ? bus.C & tl : state == SIDE_G ? !bus.C | tl : ts;
    bus.ST = go & !bus.Emergency;
    state_nx = bus.Emergency ? MAIN_G : bus.ST ? state + 2'd1 : state;
  end
  assign bus.MG = state == MAIN_G;
  assign bus.MY = state == MAIN_Y;
  assign bus.MR = state == SIDE_G || state == SIDE_Y;
  assign bus.SG = state == SIDE_G;
  assign bus.SY = state == SIDE_Y;
  assign bus.SR = state == MAIN_G || state == MAIN_Y;
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= MAIN_G;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (bus.ST | bus.Emergency) ? '0 : &cnt ? cnt : cnt + TIMER_W'(1);
    end
  end
endmodule

// File: tb/tb_traffic_main.sv
// tb_traffic_main: directed scenarios with hand-computed per-cycle lamp and ST expectations
module tb_traffic_main;
  logic Clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  traffic_main_if bus();
  traffic_main dut (.Clk(Clk), .reset(reset), .bus(bus));
  always #5 Clk = ~Clk;
  // lamp vector {MR,MY,MG,SR,SY,SG} for state code 0=MAIN_G 1=MAIN_Y 2=SIDE_G 3=SIDE_Y
  function automatic logic [5:0] lamps(input byte code);
    return code == "0" ? 6'b001100 : code == "1" ? 6'b010100 :
           code == "2" ? 6'b100001 : 6'b100010;
  endfunction
  function automatic logic [5:0] obs();
    return {bus.MR, bus.MY, bus.MG, bus.SR, bus.SY, bus.SG};
  endfunction
  task automatic do_reset(input logic c);
    @(negedge Clk);
    reset = 1'b0;
    bus.C = c;
    bus.Emergency = 1'b0;
    @(posedge Clk);
    #1 reset = 1'b1;
  endtask
  task automatic test_reset();
    @(negedge Clk);
    reset = 1'b0;
    bus.C = 1'b0;
    bus.Emergency = 1'b0;
    #1;
    tests++;
    if (obs() !== 6'b001100) begin
      fails++;
      $display("FAIL reset_lamps got %b want %b", obs(), 6'b001100);
    end
    tests++;
    if (bus.ST !== 1'b0) begin
      fails++;
      $display("FAIL reset_st got %b want 0", bus.ST);
    end
    @(posedge Clk);
    #1 reset = 1'b1;
  endtask
  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      bus.C = 1'b0;
      #1;
      tests++;
      if (obs() !== 6'b001100 || bus.ST !== 1'b0) begin
        fails++;
        $display("FAIL idle cyc %0d got lamps %b st %b want 001100 st 0", i + 1, obs(), bus.ST);
      end
    end
  endtask
  task automatic test_cycle();
    string codes = "0000011222223300";
    string sts   = "0000101000010100";
    do_reset(1'b1);
    for (int i = 0; i < codes.len(); i++) begin
      @(negedge Clk);
      bus.C = 1'b1;
      bus.Emergency = 1'b0;
      #1;
      tests++;
      if (obs() !== lamps(codes[i])) begin
        fails++;
        $display("FAIL cycle_lamps cyc %0d got %b want %b", i + 1, obs(), lamps(codes[i]));
      end
      tests++;
      if (bus.ST !== (sts[i] == "1")) begin
        fails++;
        $display("FAIL cycle_st cyc %0d got %b want %b", i + 1, bus.ST, sts[i] == "1");
      end
    end
  endtask
  task automatic test_side_drop();
    string cs    = "11111111000000";
    string codes = "00000112233000";
    string sts   = "00001010101000";
    do_reset(1'b1);
    for (int i = 0; i < codes.len(); i++) begin
      @(negedge Clk);
      bus.C = cs[i] == "1";
      bus.Emergency = 1'b0;
      #1;
      tests++;
      if (obs() !== lamps(codes[i]) || bus.ST !== (sts[i] == "1")) begin
        fails++;
        $display("FAIL side_drop cyc %0d got lamps %b st %b want %b st %b",
                 i + 1, obs(), bus.ST, lamps(codes[i]), sts[i] == "1");
      end
    end
  endtask
  task automatic test_emergency();
    string es    = "000001111000000001111000000";
    string codes = "000001000000001122000000001";
    string sts   = "000010000000010100000000010";
    do_reset(1'b1);
    for (int i = 0; i < codes.len(); i++) begin
      @(negedge Clk);
      bus.C = 1'b1;
      bus.Emergency = es[i] == "1";
      #1;
      tests++;
      if (obs() !== lamps(codes[i]) || bus.ST !== (sts[i] == "1")) begin
        fails++;
        $display("FAIL emergency cyc %0d got lamps %b st %b want %b st %b",
                 i + 1, obs(), bus.ST, lamps(codes[i]), sts[i] == "1");
      end
    end
  endtask
  task automatic test_emerg_vs_tl();
    string es    = "00001000000";
    string codes = "00000000001";
    string sts   = "00000000010";
    do_reset(1'b1);
    for (int i = 0; i < codes.len(); i++) begin
      @(negedge Clk);
      bus.C = 1'b1;
      bus.Emergency = es[i] == "1";
      #1;
      tests++;
      if (obs() !== lamps(codes[i]) || bus.ST !== (sts[i] == "1")) begin
        fails++;
        $display("FAIL emerg_vs_tl cyc %0d got lamps %b st %b want %b st %b",
                 i + 1, obs(), bus.ST, lamps(codes[i]), sts[i] == "1");
      end
    end
  endtask
  task automatic test_reset_mid();
    string codes = "000001122";
    string sts   = "000010100";
    string post_codes = "000001";
    string post_sts   = "000010";
    do_reset(1'b1);
    for (int i = 0; i < codes.len(); i++) begin
      @(negedge Clk);
      bus.C = 1'b1;
      bus.Emergency = 1'b0;
      #1;
      tests++;
      if (obs() !== lamps(codes[i]) || bus.ST !== (sts[i] == "1")) begin
        fails++;
        $display("FAIL reset_mid_pre cyc %0d got lamps %b st %b want %b st %b",
                 i + 1, obs(), bus.ST, lamps(codes[i]), sts[i] == "1");
      end
    end
    reset = 1'b0;
    #1;
    tests++;
    if (obs() !== 6'b001100 || bus.ST !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_async got lamps %b st %b want 001100 st 0", obs(), bus.ST);
    end
    @(posedge Clk);
    #1 reset = 1'b1;
    for (int i = 0; i < post_codes.len(); i++) begin
      @(negedge Clk);
      bus.C = 1'b1;
      #1;
      tests++;
      if (obs() !== lamps(post_codes[i]) || bus.ST !== (post_sts[i] == "1")) begin
        fails++;
        $display("FAIL reset_mid_post cyc %0d got lamps %b st %b want %b st %b",
                 i + 1, obs(), bus.ST, lamps(post_codes[i]), post_sts[i] == "1");
      end
    end
  endtask
  initial begin
    bus.C = 1'b0;
    bus.Emergency = 1'b0;
    test_reset();
    test_idle();
    test_cycle();
    test_side_drop();
    test_emergency();
    test_emerg_vs_tl();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
